// File: rtl/id_ex_decode_stage.sv
// RV32I decode stage: encodes ALU op, immediate and control bundle,
// registered into the ID/EX boundary with flush > stall > load priority.
package id_ex_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_XOR  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic        valid;
    alu_op_e     alu_control;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
    logic [31:0] pc;
  } id_ex_t;

  function automatic alu_op_e alu_f3(input logic [2:0] f3);
    alu_op_e op;
    unique case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

module id_ex_decode_stage
  import id_ex_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit FLAG_ILLEGAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            stall,
  input  logic            flush,
  output logic            in_ready,
  output logic            out_valid,
  output logic [3:0]      out_alu_control,
  output logic            out_alu_src_imm,
  output logic            out_alu_src_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm_sh;

  assign opc = in_instr[6:0];
  assign f7  = in_instr[31:25];
  assign f3  = in_instr[14:12];

  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25],
                   in_instr[11:7]};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31],
                   in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
  assign imm_sh = {27'b0, in_instr[24:20]};

  logic is_r;
  logic is_i;
  logic is_ld;
  logic is_st;
  logic is_br;
  logic is_lui;
  logic is_auipc;
  logic is_jal;
  logic is_jalr;

  assign is_r     = (opc == OP_R);
  assign is_i     = (opc == OP_I);
  assign is_ld    = (opc == OP_LOAD);
  assign is_st    = (opc == OP_STORE);
  assign is_br    = (opc == OP_BRANCH);
  assign is_lui   = (opc == OP_LUI);
  assign is_auipc = (opc == OP_AUIPC);
  assign is_jal   = (opc == OP_JAL);
  assign is_jalr  = (opc == OP_JALR);

  id_ex_t d;
  id_ex_t q;
  logic   ill;

  always_comb begin
    d        = '0;
    ill      = 1'b0;
    d.rs1    = in_instr[19:15];
    d.rs2    = in_instr[24:20];
    d.rd     = in_instr[11:7];
    d.funct3 = f3;
    d.pc     = in_pc;
    unique case (1'b1)
      is_r: begin
        d.reg_write = 1'b1;
        if (f7 == F7_BASE) begin
          d.alu_control = alu_f3(f3);
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          d.alu_control = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          d.alu_control = ALU_SRA;
        end else begin
          ill = 1'b1;
        end
      end
      is_i: begin
        d.reg_write   = 1'b1;
        d.alu_src_imm = 1'b1;
        d.alu_control = alu_f3(f3);
        d.imm         = imm_i;
        if (f3 == 3'b001) begin
          d.imm = imm_sh;
          ill   = (f7 != F7_BASE);
        end else if (f3 == 3'b101) begin
          d.imm = imm_sh;
          if (f7 == F7_ALT) d.alu_control = ALU_SRA;
          else ill = (f7 != F7_BASE);
        end
      end
      is_ld: begin
        d.alu_src_imm = 1'b1;
        d.imm         = imm_i;
        d.mem_read    = 1'b1;
        d.reg_write   = 1'b1;
        ill = (f3 == 3'b011) || (f3 == 3'b110) ||
              (f3 == 3'b111);
      end
      is_st: begin
        d.alu_src_imm = 1'b1;
        d.imm         = imm_s;
        d.mem_write   = 1'b1;
        ill = f3[2] || (f3 == 3'b011);
      end
      is_br: begin
        d.imm    = imm_b;
        d.branch = 1'b1;
        unique case (f3[2:1])
          2'b00:   d.alu_control = ALU_SUB;
          2'b10:   d.alu_control = ALU_SLT;
          2'b11:   d.alu_control = ALU_SLTU;
          default: ill = 1'b1;
        endcase
      end
      is_lui: begin
        d.alu_src_imm = 1'b1;
        d.imm         = imm_u;
        d.rs1         = 5'd0;
        d.reg_write   = 1'b1;
      end
      is_auipc: begin
        d.alu_src_pc  = 1'b1;
        d.alu_src_imm = 1'b1;
        d.imm         = imm_u;
        d.reg_write   = 1'b1;
      end
      is_jal: begin
        d.alu_src_pc = 1'b1;
        d.imm        = imm_j;
        d.jump       = 1'b1;
        d.reg_write  = 1'b1;
      end
      is_jalr: begin
        d.alu_src_imm = 1'b1;
        d.imm         = imm_i;
        d.jump        = 1'b1;
        d.reg_write   = 1'b1;
        ill = (f3 != 3'b000);
      end
      default: ill = 1'b1;
    endcase

    // Illegal or empty slots must never reach architectural state.
    if (ill || !in_valid) begin
      d.reg_write = 1'b0;
      d.mem_read  = 1'b0;
      d.mem_write = 1'b0;
      d.branch    = 1'b0;
      d.jump      = 1'b0;
    end
    d.illegal = in_valid & ill & FLAG_ILLEGAL;
    d.valid   = in_valid & (FLAG_ILLEGAL | ~ill);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (!stall) begin
      q <= d;
    end
  end

  assign in_ready        = ~stall;
  assign out_valid       = q.valid;
  assign out_alu_control = q.alu_control;
  assign out_alu_src_imm = q.alu_src_imm;
  assign out_alu_src_pc  = q.alu_src_pc;
  assign out_imm         = q.imm;
  assign out_rs1         = q.rs1;
  assign out_rs2         = q.rs2;
  assign out_rd          = q.rd;
  assign out_funct3      = q.funct3;
  assign out_reg_write   = q.reg_write;
  assign out_mem_read    = q.mem_read;
  assign out_mem_write   = q.mem_write;
  assign out_branch      = q.branch;
  assign out_jump        = q.jump;
  assign out_illegal     = q.illegal;
  assign out_pc          = q.pc;

endmodule
